// File: rtl/aes128_round_ctrl_pkg.sv
// Shared AES-128 definitions: round count, FSM encoding, rcon table and the
// byte-level round primitives used by the controller and the key-step cell.
package aes128_round_ctrl_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] aes_rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = aes_sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte n sits at [127-8n -: 8]; byte 4c+r is row r of column c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c+r)%4)+r)) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] aes_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c) +: 8];
            a1 = s[8*(14-4*c) +: 8];
            a2 = s[8*(13-4*c) +: 8];
            a3 = s[8*(12-4*c) +: 8];
            o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives the next round key from the current
// one and the round constant (four S-box lookups on the rotated last word).
module aes_key_step
    import aes128_round_ctrl_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = rk_in[127:96];
    assign w1 = rk_in[95:64];
    assign w2 = rk_in[63:32];
    assign w3 = rk_in[31:0];

    assign rot  = {w3[23:0], w3[31:24]};
    assign temp = {aes_sbox(rot[31:24]), aes_sbox(rot[23:16]),
                   aes_sbox(rot[15:8]),  aes_sbox(rot[7:0])} ^ {rcon, 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one full round per clock through a
// shared round datapath, with the round key expanded on the fly.
module aes128_round_ctrl
    import aes128_round_ctrl_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy,
    output logic [3:0]   round_cnt
);

    if (NR != AES_NR) begin : g_bad_nr
        $error("aes128_round_ctrl: only NR=10 (AES-128) is supported");
    end

    localparam logic [3:0] PRE_FINAL_RND = 4'(NR - 1);
    localparam logic [3:0] FINAL_RND     = 4'(NR);

    state_t       state_q, state_d;
    logic [127:0] st_q, rk_q;
    logic [3:0]   rnd_q;
    logic         load, step, done_ack;
    logic [7:0]   rcon;
    logic [127:0] rk_next, shifted, round_out;

    assign rcon = aes_rcon(rnd_q);

    aes_key_step u_key_step (
        .rk_in  (rk_q),
        .rcon   (rcon),
        .rk_out (rk_next)
    );

    // The last round skips MixColumns; everything else shares the same path.
    assign shifted   = shift_rows(sub_bytes(st_q));
    assign round_out = ((state_q == ST_FINAL) ? shifted : aes_mix_columns(shifted)) ^ rk_next;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        done_ack  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                busy = 1'b1;
                step = 1'b1;
                if (rnd_q == PRE_FINAL_RND) state_d = ST_FINAL;
            end
            ST_FINAL: begin
                busy    = 1'b1;
                step    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done_ack = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= '0;
            rk_q  <= '0;
            rnd_q <= '0;
        end else if (load) begin
            st_q  <= data_in ^ key_in;
            rk_q  <= key_in;
            rnd_q <= 4'd1;
        end else if (step) begin
            st_q <= round_out;
            rk_q <= rk_next;
            if (rnd_q != FINAL_RND) rnd_q <= rnd_q + 4'd1;
        end else if (done_ack) begin
            rnd_q <= '0;
        end
    end

    assign data_out  = st_q;
    assign round_cnt = rnd_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Randomised self-checking bench for aes128_round_ctrl against a byte-array
// AES-128 reference model plus the FIPS-197 known-answer vectors.
module tb_aes128_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] key_in, data_in, data_out;
    logic [3:0]   round_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb [256];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    always #5 clk = ~clk;

    aes128_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_in    (key_in),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy),
        .round_cnt (round_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // S-box built with the generator/log-walk construction rather than an inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[4*(((i/4) + (i%4)) % 4) + (i%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 128'(in_ready), 128'(1));
    endtask

    // Waits for out_valid after E0; returns edges elapsed plus busy/round_cnt observations.
    task automatic wait_result(output int n, output int busy_n, output int rc_bad, output int rdy_n);
        n = 0; busy_n = 0; rc_bad = 0; rdy_n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            if (busy === 1'b1) busy_n++;
            if (in_ready === 1'b1) rdy_n++;
            if (round_cnt !== 4'(n + 1)) rc_bad++;
            tick();
            n++;
        end
    endtask

    task automatic send_block(input logic [127:0] key, input logic [127:0] pt,
                              input logic [127:0] exp, input int hold, input string tag);
        int n, busy_n, rc_bad, rdy_n, unstable;
        wait_ready(tag);
        key_in = key; data_in = pt; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        key_in = rand128(); data_in = rand128();
        wait_result(n, busy_n, rc_bad, rdy_n);
        check({tag, "_lat"},   128'(n),      128'(10));
        check({tag, "_busy"},  128'(busy_n), 128'(10));
        check({tag, "_rcnt"},  128'(rc_bad), 128'(0));
        check({tag, "_data"},  data_out,     exp);
        unstable = 0;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (out_valid !== 1'b1 || data_out !== exp) unstable++;
        end
        if (hold > 0) check({tag, "_hold"}, 128'(unstable), 128'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_rdy"}, 128'(in_ready),  128'(1));
        check({tag, "_idle_ov"},  128'(out_valid), 128'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy_n, rc_bad, rdy_n, bad, ov_seen, cyc, sent, recv;
        bit change_next;
        logic [127:0] k, p;
        logic [127:0] exp_q[$];
        int acc_q[$];

        build_sbox();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; key_in = '0; data_in = '0;
        #12;
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        check("rst_round_cnt", 128'(round_cnt), 128'(0));
        check("rst_data_out",  data_out,        128'(0));
        rst = 1'b0;

        send_block(KEY_B, PT_B, CT_B, 0, "appb");
        send_block(KEY_C, PT_C, CT_C, 2, "appc");
        send_block('0, '0, CT_Z, 20, "zero");

        // in_valid held with a second block throughout busy and DONE
        wait_ready("ign");
        key_in = KEY_B; data_in = PT_B; in_valid = 1'b1;
        tick();
        key_in = KEY_C; data_in = PT_C;
        wait_result(n, busy_n, rc_bad, rdy_n);
        check("ign_lat",   128'(n),     128'(10));
        check("ign_rdy",   128'(rdy_n), 128'(0));
        check("ign_first", data_out,    CT_B);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== CT_B) bad++;
        end
        check("ign_done_hold", 128'(bad), 128'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ign_idle_rdy", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        wait_result(n, busy_n, rc_bad, rdy_n);
        check("ign_lat2",   128'(n),  128'(10));
        check("ign_second", data_out, CT_C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset in the middle of round 5
        wait_ready("rst");
        key_in = rand128(); data_in = rand128(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_cnt !== 4'd5 && n < 20) begin
            tick();
            n++;
        end
        check("rst_mid_reach", 128'(round_cnt), 128'(5));
        #2 rst = 1'b1;
        #1;
        check("rst_mid_in_ready",  128'(in_ready),  128'(1));
        check("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check("rst_mid_busy",      128'(busy),      128'(0));
        check("rst_mid_round_cnt", 128'(round_cnt), 128'(0));
        check("rst_mid_data_out",  data_out,        128'(0));
        tick();
        tick();
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0) ov_seen++;
        end
        check("rst_no_output", 128'(ov_seen), 128'(0));
        send_block(KEY_B, PT_B, CT_B, 0, "appb_post_rst");

        // random blocks against the model
        for (int b = 0; b < 6; b++) begin
            k = rand128();
            p = rand128();
            send_block(k, p, aes_ref(k, p), int'($urandom_range(0, 3)), $sformatf("rnd%0d", b));
        end

        // back-to-back with in_valid and out_ready tied high
        key_in = rand128(); data_in = rand128();
        in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; sent = 0; recv = 0; change_next = 1'b0;
        while (recv < 4 && cyc < 100) begin
            if (out_valid === 1'b1) begin
                check($sformatf("b2b%0d_data", recv), data_out, exp_q.pop_front());
                check($sformatf("b2b%0d_lat", recv), 128'(cyc - acc_q[recv]), 128'(10));
                recv++;
            end
            if (in_ready === 1'b1 && sent < 4) begin
                exp_q.push_back(aes_ref(key_in, data_in));
                acc_q.push_back(cyc + 1);
                sent++;
                change_next = 1'b1;
            end
            tick();
            cyc++;
            if (change_next) begin
                key_in = rand128(); data_in = rand128();
                if (sent == 4) in_valid = 1'b0;
                change_next = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_count", 128'(recv), 128'(4));
        for (int i = 1; i < acc_q.size(); i++)
            check($sformatf("b2b%0d_period", i), 128'(acc_q[i] - acc_q[i-1]), 128'(12));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
